// File: rtl/sa_pmod_pkg.sv
// Shared definitions for the PmodADC SA converter blocks (ADC receive and DAC transmit).
// Holds the transfer FSM state type, the default geometry of the external shift register,
// and a small helper for sizing counters.
package sa_pmod_pkg;

    localparam int unsigned DefDataW  = 14;
    localparam int unsigned DefSrBits = 16;
    localparam int unsigned DefClkDiv = 4;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StLatch
    } sa_state_e;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sa_sclk_gen.sv
// SClk generator for the PmodADC serial interface.
// Divides clk_i by CLK_DIV per SClk half-period. Each bit starts with the low phase.
//   clk_i, reset_ni : system clock, synchronous active-low reset
//   en_i            : advance the divider
//   clr_i           : restart at the beginning of a low phase (wins over en_i)
//   sclk_o          : registered SClk level
//   phase_end_o     : last cycle of the current half-period
//   bit_end_o       : last cycle of the high half-period (end of one bit)
module sa_sclk_gen
    import sa_pmod_pkg::*;
#(
    parameter int unsigned CLK_DIV = DefClkDiv
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic en_i,
    input  logic clr_i,
    output logic sclk_o,
    output logic phase_end_o,
    output logic bit_end_o
);

    localparam int unsigned DivW = cnt_width(CLK_DIV);
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

    logic [DivW-1:0] div_q;
    logic            phase_q;

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            div_q   <= '0;
            phase_q <= 1'b0;
        end else if (clr_i) begin
            div_q   <= '0;
            phase_q <= 1'b0;
        end else if (en_i) begin
            if (div_q == DivLast) begin
                div_q   <= '0;
                phase_q <= ~phase_q;
            end else begin
                div_q <= div_q + DivW'(1);
            end
        end
    end

    assign phase_end_o = en_i && (div_q == DivLast);
    assign bit_end_o   = phase_end_o && phase_q;
    assign sclk_o      = phase_q;

endmodule

// File: rtl/sa_dac_tx.sv
// SA DAC transmitter: takes parallel samples over valid/ready, shifts them MSB-first
// (zero padding first) into the PmodADC shift register, then pulses LClk so the
// R-2R DAC updates. All pin outputs are registered.
//   clk_i, reset_ni : system clock, synchronous active-low reset
//   data_i          : sample, unsigned straight binary
//   data_valid_i    : data_i valid
//   data_ready_o    : a sample can be accepted this cycle
//   DAC_Ser_o       : serial data, stable around SClk rise
//   DAC_SClk_o      : shift clock
//   DAC_LClk_o      : latch clock, high for CLK_DIV cycles after the last bit
//   DAC_busy_o      : transfer in SHIFT or LATCH
// Optional: define SA_DAC_TX_DBUF_EN for a one-entry holding register that lets the
// next sample be accepted while a transfer is running and started with no IDLE gap.
module sa_dac_tx
    import sa_pmod_pkg::*;
#(
    parameter int unsigned DATA_W  = DefDataW,
    parameter int unsigned SR_BITS = DefSrBits,
    parameter int unsigned CLK_DIV = DefClkDiv
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic [DATA_W-1:0] data_i,
    input  logic              data_valid_i,
    output logic              data_ready_o,
    output logic              DAC_Ser_o,
    output logic              DAC_SClk_o,
    output logic              DAC_LClk_o,
    output logic              DAC_busy_o
);

    localparam int unsigned CntW = $clog2(SR_BITS + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(SR_BITS - 1);

    sa_state_e          state_q;
    logic [SR_BITS-1:0] sr_q;
    logic [CntW-1:0]    bit_cnt_q;
    logic               lclk_q;
    logic               busy_q;
    logic               ready_q;

    logic accept;
    logic gen_en;
    logic gen_clr;
    logic phase_end;
    logic bit_end;
    logic latch_done;

    assign accept     = data_valid_i && ready_q;
    assign gen_en     = (state_q != StIdle);
    assign latch_done = (state_q == StLatch) && phase_end;
    // Restarting at LATCH exit keeps SClk low in IDLE and aligns a directly following word.
    assign gen_clr    = (state_q == StIdle) || latch_done;

    sa_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk_i       (clk_i),
        .reset_ni    (reset_ni),
        .en_i        (gen_en),
        .clr_i       (gen_clr),
        .sclk_o      (DAC_SClk_o),
        .phase_end_o (phase_end),
        .bit_end_o   (bit_end)
    );

`ifdef SA_DAC_TX_DBUF_EN
    logic [DATA_W-1:0] hold_q;
    logic              hold_full_q;
`endif

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q   <= StIdle;
            sr_q      <= '0;
            bit_cnt_q <= '0;
            lclk_q    <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
`ifdef SA_DAC_TX_DBUF_EN
            hold_q      <= '0;
            hold_full_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
`ifdef SA_DAC_TX_DBUF_EN
                    ready_q <= 1'b1;
`else
                    ready_q <= !accept;
`endif
                    if (accept) begin
                        sr_q      <= SR_BITS'(data_i);
                        bit_cnt_q <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= StShift;
                    end
                end
                StShift: begin
                    if (bit_end) begin
                        // Zero fill leaves Ser low once the word is out.
                        sr_q      <= {sr_q[SR_BITS-2:0], 1'b0};
                        bit_cnt_q <= bit_cnt_q + CntW'(1);
                        if (bit_cnt_q == CntLast) begin
                            state_q <= StLatch;
                            lclk_q  <= 1'b1;
                        end
                    end
                end
                StLatch: begin
                    if (phase_end) begin
                        lclk_q <= 1'b0;
`ifdef SA_DAC_TX_DBUF_EN
                        if (hold_full_q) begin
                            sr_q      <= SR_BITS'(hold_q);
                            bit_cnt_q <= '0;
                            state_q   <= StShift;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= StIdle;
                        end
`else
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= StIdle;
`endif
                    end
                end
                default: state_q <= StIdle;
            endcase

`ifdef SA_DAC_TX_DBUF_EN
            // A sample accepted while busy waits here; an accept in the drain cycle refills it.
            if (accept && (state_q != StIdle)) begin
                hold_q      <= data_i;
                hold_full_q <= 1'b1;
                ready_q     <= 1'b0;
            end else if (latch_done && hold_full_q) begin
                hold_full_q <= 1'b0;
                ready_q     <= 1'b1;
            end
`endif
        end
    end

    assign DAC_Ser_o    = sr_q[SR_BITS-1];
    assign DAC_LClk_o   = lclk_q;
    assign DAC_busy_o   = busy_q;
    assign data_ready_o = ready_q;

endmodule

// File: tb/tb_sa_dac_tx.sv
// Directed bench for sa_dac_tx: one instance at default geometry, one with CLK_DIV=1.
// Cycle numbering: the accept edge ends cycle 0; outputs sampled on falling edges.
module tb_sa_dac_tx;

    logic        clk = 1'b0;
    logic        reset_ni = 1'b0;
    logic [13:0] data0 = '0, data1 = '0;
    logic        valid0 = 1'b0, valid1 = 1'b0;
    logic        ready0, ser0, sclk0, lclk0, busy0;
    logic        ready1, ser1, sclk1, lclk1, busy1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sa_dac_tx #(.DATA_W(14), .SR_BITS(16), .CLK_DIV(4)) u_dut (
        .clk_i (clk), .reset_ni (reset_ni), .data_i (data0), .data_valid_i (valid0),
        .data_ready_o (ready0), .DAC_Ser_o (ser0), .DAC_SClk_o (sclk0),
        .DAC_LClk_o (lclk0), .DAC_busy_o (busy0)
    );

    sa_dac_tx #(.DATA_W(14), .SR_BITS(16), .CLK_DIV(1)) u_dut1 (
        .clk_i (clk), .reset_ni (reset_ni), .data_i (data1), .data_valid_i (valid1),
        .data_ready_o (ready1), .DAC_Ser_o (ser1), .DAC_SClk_o (sclk1),
        .DAC_LClk_o (lclk1), .DAC_busy_o (busy1)
    );

    bit   sel = 1'b0;
    logic ready_m, ser_m, sclk_m, lclk_m, busy_m;
    assign ready_m = sel ? ready1 : ready0;
    assign ser_m   = sel ? ser1   : ser0;
    assign sclk_m  = sel ? sclk1  : sclk0;
    assign lclk_m  = sel ? lclk1  : lclk0;
    assign busy_m  = sel ? busy1  : busy0;

    // Results of the last observe() call.
    int          n_rises, first_rise, last_rise, lclk_at, lclk_len, ready_at, latch_bad;
    logic [31:0] bits;
    logic        busy_c1, busy_rdy;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Offer a sample to the selected DUT; returns just after the accept edge.
    task automatic do_accept(input logic [13:0] d, input bit keep_valid);
        int waited = 0;
        @(negedge clk);
        if (sel) begin data1 = d; valid1 = 1'b1; end
        else     begin data0 = d; valid0 = 1'b1; end
        while (!ready_m && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        check_eq("ready_timeout", 32'(waited < 400), 32'd1);
        @(posedge clk);
        #1;
        if (!keep_valid) begin
            valid0 = 1'b0;
            valid1 = 1'b0;
        end
    endtask

    // Sample cycles 1..n after an accept edge.
    task automatic observe(input int n);
        logic prev = 1'b0;
        n_rises = 0; first_rise = 0; last_rise = 0; lclk_at = 0; lclk_len = 0;
        ready_at = 0; latch_bad = 0; bits = '0; busy_c1 = 1'b0; busy_rdy = 1'b1;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            if (c == 1) busy_c1 = busy_m;
            if (sclk_m && !prev) begin
                n_rises++;
                bits = {bits[30:0], ser_m};
                if (first_rise == 0) first_rise = c;
                last_rise = c;
            end
            prev = sclk_m;
            if (lclk_m) begin
                if (lclk_at == 0) lclk_at = c;
                lclk_len++;
                if (sclk_m || ser_m) latch_bad++;
            end
            if (ready_m && ready_at == 0) begin
                ready_at = c;
                busy_rdy = busy_m;
            end
        end
    endtask

    initial begin
        int   r1, r2, lclk_seen;
        logic prev_l, drop_next;

        // Reset values, then release.
        repeat (3) @(negedge clk);
        check_eq("rst_pins", {28'd0, ser0, sclk0, lclk0, busy0}, 32'd0);
        check_eq("rst_ready", 32'(ready0), 32'd0);
        reset_ni = 1'b1;
        @(negedge clk);
        check_eq("rel_ready", {30'd0, ready0, ready1}, 32'b11);
        check_eq("rel_pins", {28'd0, ser0, sclk0, lclk0, busy0}, 32'd0);

        // Single word 14'h2A5C.
        do_accept(14'h2A5C, 1'b0);
        observe(133);
        check_eq("w1_bits", bits, 32'h2A5C);
        check_eq("w1_rises", n_rises, 16);
        check_eq("w1_first_rise", first_rise, 5);
        check_eq("w1_last_rise", last_rise, 125);
        check_eq("w1_lclk_at", lclk_at, 129);
        check_eq("w1_lclk_len", lclk_len, 4);
        check_eq("w1_latch_quiet", latch_bad, 0);
        check_eq("w1_busy_c1", 32'(busy_c1), 32'd1);
        check_eq("w1_ready_at", ready_at, 133);
        check_eq("w1_busy_idle", 32'(busy_rdy), 32'd0);

        // Back-to-back 14'h3FFF then 14'h0000 with valid held.
        do_accept(14'h3FFF, 1'b1);
        data0 = 14'h0000;
        observe(133);
        check_eq("b2b_w1_bits", bits, 32'h3FFF);
        check_eq("b2b_w1_rises", n_rises, 16);
        check_eq("b2b_accept_at", ready_at, 133);
        @(posedge clk);
        #1;
        valid0 = 1'b0;
        observe(133);
        check_eq("b2b_w2_bits", bits, 32'h0);
        check_eq("b2b_w2_rises", n_rises, 16);
        check_eq("b2b_w2_lclk_at", lclk_at, 129);
        check_eq("b2b_w2_busy_c1", 32'(busy_c1), 32'd1);

        // Reset during the high phase of the seventh bit of 14'h1234.
        do_accept(14'h1234, 1'b0);
        lclk_seen = 0;
        for (int c = 1; c <= 54; c++) begin
            @(negedge clk);
            if (lclk0) lclk_seen++;
        end
        check_eq("mid_pre_sclk_ser", {30'd0, sclk0, ser0}, 32'b11);
        reset_ni = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_pins", {28'd0, ser0, sclk0, lclk0, busy0}, 32'd0);
        check_eq("mid_no_lclk", lclk_seen, 0);
        reset_ni = 1'b1;
        @(negedge clk);
        check_eq("mid_rel_ready", 32'(ready0), 32'd1);
        do_accept(14'h0001, 1'b0);
        observe(133);
        check_eq("post_rst_bits", bits, 32'h1);
        check_eq("post_rst_lclk_at", lclk_at, 129);

        // CLK_DIV=1 instance, 14'h0001.
        sel = 1'b1;
        do_accept(14'h0001, 1'b0);
        observe(34);
        check_eq("d1_bits", bits, 32'h1);
        check_eq("d1_rises", n_rises, 16);
        check_eq("d1_first_rise", first_rise, 2);
        check_eq("d1_last_rise", last_rise, 32);
        check_eq("d1_lclk_at", lclk_at, 33);
        check_eq("d1_lclk_len", lclk_len, 1);
        check_eq("d1_ready_at", ready_at, 34);
        sel = 1'b0;

        // Second sample offered at cycle 5 of a transfer.
        do_accept(14'h2A5C, 1'b0);
        repeat (4) @(negedge clk);
        @(negedge clk);
`ifdef SA_DAC_TX_DBUF_EN
        check_eq("c5_ready", 32'(ready0), 32'd1);
`else
        check_eq("c5_ready", 32'(ready0), 32'd0);
`endif
        data0 = 14'h0F0F;
        valid0 = 1'b1;
        drop_next = ready0;
        prev_l = lclk0;
        r1 = 0;
        r2 = 0;
        for (int c = 6; c <= 300; c++) begin
            @(negedge clk);
            if (drop_next) valid0 = 1'b0;
            drop_next = valid0 && ready0;
            if (lclk0 && !prev_l) begin
                if (r1 == 0) r1 = c;
                else if (r2 == 0) r2 = c;
            end
            prev_l = lclk0;
        end
        check_eq("c5_lclk1", r1, 129);
`ifdef SA_DAC_TX_DBUF_EN
        check_eq("c5_lclk2", r2, 261);
`else
        check_eq("c5_lclk2", r2, 262);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
